rv32_dmem_bridge: RTL and testbench

//  Sits downstream of the RV32I core's data memory port. Converts the core's single-cycle writes and stalling reads into an Avalon-MM pipelined master.

---
 rtl/rv32_dmem_bridge.sv | 192 +++++++++++++++++++
 tb/tb_rv32_dmem_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_dmem_bridge.sv
// Bridges the RV32I core data port onto a pipelined Avalon-MM master: posted
// writes through a small FIFO, stalled reads ordered behind buffered writes.
module rv32_dmem_bridge #(
    parameter logic [31:0] TIMER_BASE_ADDR = 32'hAFFFFFE0,
    parameter int unsigned WBUF_LOG2_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddress,
    input  logic        dwrite,
    input  logic [31:0] dwritedata,
    input  logic [3:0]  dbyteenable,
    input  logic        dread,
    output logic [31:0] dreaddata,
    output logic        dwaitrequest,
    output logic [31:0] m_address,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    input  logic        m_waitrequest,
    output logic        wr_mtime,
    output logic        wr_mtimecmp,
    output logic        wr_mtime_upper,
    output logic [31:0] wr_mtime_val,
    output logic        wbuf_overflow
);
    localparam int unsigned DEPTH = 2 ** WBUF_LOG2_DEPTH;
    localparam int unsigned PW    = WBUF_LOG2_DEPTH;
    localparam int unsigned CW    = WBUF_LOG2_DEPTH + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_REQ  = 2'd1;
    localparam logic [1:0] RD_DATA = 2'd2;
    localparam logic [1:0] RD_DONE = 2'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wbuf_entry_t;

    logic [1:0]    state_q, state_d;
    logic [31:0]   rd_addr_q, rd_addr_d;
    logic [31:0]   dreaddata_q, dreaddata_d;
    wbuf_entry_t   wbuf_q [DEPTH];
    wbuf_entry_t   wbuf_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          wr_mtime_q, wr_mtime_d;
    logic          wr_mtimecmp_q, wr_mtimecmp_d;
    logic          wr_mtime_upper_q, wr_mtime_upper_d;
    logic [31:0]   wr_mtime_val_q, wr_mtime_val_d;

    logic        timer_hit, tmr_wr, push, accept, pop;
    logic        wbuf_empty, wbuf_full, wr_active, rd_done;
    wbuf_entry_t head;

    // Address decode and write-buffer handshake terms
    always_comb begin
        timer_hit  = daddress[31:4] == TIMER_BASE_ADDR[31:4];
        tmr_wr     = dwrite & timer_hit;
        push       = dwrite & ~timer_hit;
        wbuf_empty = count_q == '0;
        wbuf_full  = count_q == CW'(DEPTH);
        wr_active  = (state_q == IDLE) & ~wbuf_empty;
        pop        = wr_active & ~m_waitrequest;
        accept     = push & (~wbuf_full | pop);
        rd_done    = state_q == RD_DONE;
        head       = wbuf_q[rd_ptr_q];
    end

    // Avalon master and core-facing outputs; read cycles own the bus exclusively
    always_comb begin
        m_read       = state_q == RD_REQ;
        m_write      = wr_active;
        m_address    = '0;
        m_writedata  = '0;
        m_byteenable = '0;
        if (state_q == RD_REQ) begin
            m_address    = rd_addr_q;
            m_byteenable = 4'hF;
        end else if (wr_active) begin
            m_address    = head.addr;
            m_writedata  = head.data;
            m_byteenable = head.be;
        end
        dwaitrequest   = dread & ~rd_done;
        dreaddata      = dreaddata_q;
        wbuf_overflow  = overflow_q;
        wr_mtime       = wr_mtime_q;
        wr_mtimecmp    = wr_mtimecmp_q;
        wr_mtime_upper = wr_mtime_upper_q;
        wr_mtime_val   = wr_mtime_val_q;
    end

    // Write FIFO; a push into a full buffer only survives if the head pops this cycle
    always_comb begin
        wbuf_d     = wbuf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (accept) begin
            wbuf_d[wr_ptr_q] = '{addr: daddress, data: dwritedata, be: dbyteenable};
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end else if (push) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(accept) - CW'(pop);
    end

    // Read FSM; a read may only launch once no write is buffered or arriving
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        dreaddata_d = dreaddata_q;
        case (state_q)
            IDLE: begin
                if (dread & ~rd_done) begin
                    if (timer_hit) begin
                        state_d     = RD_DONE;
                        dreaddata_d = '0;
                    end else if (wbuf_empty & ~push) begin
                        state_d   = RD_REQ;
                        rd_addr_d = daddress;
                    end
                end
            end
            RD_REQ: begin
                if (~m_waitrequest) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_readdatavalid) begin
                    state_d     = RD_DONE;
                    dreaddata_d = m_readdata;
                end
            end
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Timer window writes become one-cycle update strobes
    always_comb begin
        wr_mtime_d       = tmr_wr & ~daddress[3];
        wr_mtimecmp_d    = tmr_wr & daddress[3];
        wr_mtime_upper_d = tmr_wr & daddress[2];
        wr_mtime_val_d   = tmr_wr ? dwritedata : wr_mtime_val_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            rd_addr_q        <= '0;
            dreaddata_q      <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            overflow_q       <= 1'b0;
            wr_mtime_q       <= 1'b0;
            wr_mtimecmp_q    <= 1'b0;
            wr_mtime_upper_q <= 1'b0;
            wr_mtime_val_q   <= '0;
        end else begin
            state_q          <= state_d;
            rd_addr_q        <= rd_addr_d;
            dreaddata_q      <= dreaddata_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            overflow_q       <= overflow_d;
            wr_mtime_q       <= wr_mtime_d;
            wr_mtimecmp_q    <= wr_mtimecmp_d;
            wr_mtime_upper_q <= wr_mtime_upper_d;
            wr_mtime_val_q   <= wr_mtime_val_d;
        end
    end

    // Buffer payload needs no reset: entries are only visible behind count_q
    always_ff @(posedge clk) begin
        wbuf_q <= wbuf_d;
    end
endmodule

// File: tb/tb_rv32_dmem_bridge.sv
// Bench for rv32_dmem_bridge: Avalon slave memory, core-level reference model,
// timer-write vector table, directed latency/ordering sequences and random traffic.
module tb_rv32_dmem_bridge;
    localparam logic [31:0] TBASE = 32'hAFFFFFE0;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, dwrite, dread;
    logic [31:0] daddress, dwritedata;
    logic [3:0]  dbyteenable;
    logic [31:0] dreaddata, m_address, m_writedata, m_readdata, wr_mtime_val;
    logic        dwaitrequest, m_write, m_read, m_readdatavalid, m_waitrequest;
    logic [3:0]  m_byteenable;
    logic        wr_mtime, wr_mtimecmp, wr_mtime_upper, wbuf_overflow;

    always #5 clk = ~clk;

    rv32_dmem_bridge #(.TIMER_BASE_ADDR(TBASE), .WBUF_LOG2_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .daddress(daddress), .dwrite(dwrite),
        .dwritedata(dwritedata), .dbyteenable(dbyteenable), .dread(dread),
        .dreaddata(dreaddata), .dwaitrequest(dwaitrequest), .m_address(m_address),
        .m_write(m_write), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_read(m_read), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .m_waitrequest(m_waitrequest), .wr_mtime(wr_mtime), .wr_mtimecmp(wr_mtimecmp),
        .wr_mtime_upper(wr_mtime_upper), .wr_mtime_val(wr_mtime_val),
        .wbuf_overflow(wbuf_overflow)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        mt;
        logic        cmp;
        logic        up;
        logic        avw;
    } tvec_t;

    int tests = 0, fails = 0;
    int cyc_no = 0, n_avw = 0, mr_cycles = 0, mw_first = -1, mr_first = -1;
    wr_t exp_q[$];
    logic [31:0] model_mem [16];
    logic [31:0] slave_mem [16];
    logic exp_ovf, exp_mt, exp_cmp, exp_up;
    logic [31:0] exp_val;
    int wait_left = 0, rdv_delay = 1, rd_cnt = 0;
    bit wait_rand = 0, auto_rdv = 1, rd_pend = 0, rd_complete = 0;
    logic [31:0] rd_val;
    logic s_dwait, s_mread, s_mwrite, s_mt, s_cmp, s_up, s_ovf, s_acc;
    logic [31:0] s_rdata, s_maddr, s_mwdata, s_val;
    logic [3:0] s_mbe;

    function automatic bit is_timer(logic [31:0] a);
        return a[31:4] == TBASE[31:4];
    endfunction

    function automatic bit in_ram(logic [31:0] a);
        return a[31:6] == 26'h40;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return TBASE + 32'($urandom_range(0, 3) * 4);
        return 32'h1000 + 32'($urandom_range(0, 15) * 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %h, expected no such event", name, act);
    endtask

    // One clock: sample and check at the negedge, then update the slave after the posedge
    task automatic cyc();
        wr_t w;
        logic [31:0] exp_rd;
        @(negedge clk);
        cyc_no++;
        s_dwait = dwaitrequest; s_rdata = dreaddata; s_mread = m_read; s_mwrite = m_write;
        s_maddr = m_address; s_mwdata = m_writedata; s_mbe = m_byteenable;
        s_mt = wr_mtime; s_cmp = wr_mtimecmp; s_up = wr_mtime_upper; s_val = wr_mtime_val;
        s_ovf = wbuf_overflow; s_acc = m_read & ~m_waitrequest;
        rd_complete = 0;
        if (!reset) begin
            chk("wr_mtime", 32'(wr_mtime), 32'(exp_mt));
            chk("wr_mtimecmp", 32'(wr_mtimecmp), 32'(exp_cmp));
            if (exp_mt | exp_cmp) begin
                chk("wr_mtime_upper", 32'(wr_mtime_upper), 32'(exp_up));
                chk("wr_mtime_val", wr_mtime_val, exp_val);
            end
            chk("rw_exclusive", 32'(m_read & m_write), 32'h0);
            chk("wbuf_overflow", 32'(wbuf_overflow), 32'(exp_ovf));
            if (m_write && mw_first < 0) mw_first = cyc_no;
            if (m_read) begin
                mr_cycles++;
                if (mr_first < 0) mr_first = cyc_no;
                chk("rd_m_address", m_address, daddress);
                chk("rd_byteenable", 32'(m_byteenable), 32'hF);
            end
            if (m_write && !m_waitrequest) begin
                n_avw++;
                if (exp_q.size() == 0) fail_now("spurious_m_write", m_address);
                else begin
                    w = exp_q.pop_front();
                    chk("avw_address", m_address, w.a);
                    chk("avw_data", m_writedata, w.d);
                    chk("avw_be", 32'(m_byteenable), 32'(w.be));
                    if (in_ram(m_address))
                        slave_mem[m_address[5:2]] = merge(slave_mem[m_address[5:2]], m_writedata, m_byteenable);
                end
            end
            if (s_acc && auto_rdv) begin
                rd_pend = 1;
                rd_cnt = rdv_delay;
                rd_val = in_ram(m_address) ? slave_mem[m_address[5:2]] : 32'h0;
            end
            exp_mt  = dwrite & is_timer(daddress) & ~daddress[3];
            exp_cmp = dwrite & is_timer(daddress) & daddress[3];
            exp_up  = daddress[2];
            exp_val = dwritedata;
            if (dwrite && !is_timer(daddress)) begin
                if (exp_q.size() < DEPTH) begin
                    w.a = daddress; w.d = dwritedata; w.be = dbyteenable;
                    exp_q.push_back(w);
                    if (in_ram(daddress))
                        model_mem[daddress[5:2]] = merge(model_mem[daddress[5:2]], dwritedata, dbyteenable);
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            if (dread && !dwaitrequest) begin
                exp_rd = is_timer(daddress) ? 32'h0 : (in_ram(daddress) ? model_mem[daddress[5:2]] : 32'h0);
                chk("rd_data", dreaddata, exp_rd);
                rd_complete = 1;
            end
        end
        @(posedge clk);
        #1;
        m_readdatavalid = 1'b0;
        m_readdata = $urandom;
        if (rd_pend) begin
            rd_cnt--;
            if (rd_cnt <= 0) begin
                m_readdatavalid = 1'b1;
                m_readdata = rd_val;
                rd_pend = 0;
            end
        end
        m_waitrequest = (wait_left > 0) || (wait_rand && $urandom_range(0, 3) == 0);
        if (wait_left > 0) wait_left--;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_ovf = 0; exp_mt = 0; exp_cmp = 0; exp_up = 0; exp_val = '0;
        rd_pend = 0; wait_left = 0;
        for (int i = 0; i < 16; i++) model_mem[i] = slave_mem[i];
    endtask

    task automatic do_reset(input int n);
        reset = 1; dread = 0; dwrite = 0;
        repeat (n) cyc();
        reset = 0;
        model_reset();
    endtask

    task automatic do_read(input logic [31:0] a, output int lat);
        dread = 1; daddress = a; dwrite = 0; lat = -1;
        for (int t = 0; t < 80; t++) begin
            cyc();
            if (rd_complete) begin
                lat = t;
                break;
            end
        end
        dread = 0;
        if (lat < 0) fail_now("rd_timeout", a);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tvec_t tv [6];
        int lat, rd_wait;
        tv[0] = '{TBASE + 32'h0,  32'h11110000, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[1] = '{TBASE + 32'h4,  32'h12345678, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[2] = '{TBASE + 32'h8,  32'h22220000, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[3] = '{TBASE + 32'hC,  32'h3333CCCC, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[4] = '{TBASE + 32'h10, 32'h44440000, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[5] = '{TBASE - 32'h10, 32'h55550000, 1'b0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = 32'hA5A50000 | 32'(i);
            model_mem[i] = slave_mem[i];
        end
        reset = 1; dread = 0; dwrite = 0; daddress = '0; dwritedata = '0; dbyteenable = '0;
        m_readdata = '0; m_readdatavalid = 0; m_waitrequest = 0;

        // Reset values
        do_reset(2);
        chk("rst_dwaitrequest", 32'(s_dwait), 32'h0);
        chk("rst_m_read", 32'(s_mread), 32'h0);
        chk("rst_m_write", 32'(s_mwrite), 32'h0);
        chk("rst_m_address", s_maddr, 32'h0);
        chk("rst_m_writedata", s_mwdata, 32'h0);
        chk("rst_m_byteenable", 32'(s_mbe), 32'h0);
        chk("rst_wr_mtime", 32'(s_mt), 32'h0);
        chk("rst_wr_mtimecmp", 32'(s_cmp), 32'h0);
        chk("rst_wr_mtime_upper", 32'(s_up), 32'h0);
        chk("rst_wr_mtime_val", s_val, 32'h0);
        chk("rst_wbuf_overflow", 32'(s_ovf), 32'h0);
        chk("rst_dreaddata", s_rdata, 32'h0);

        // Write then read the same word: write must reach the bus first
        mw_first = -1; mr_first = -1;
        dwrite = 1; daddress = 32'h1000; dwritedata = 32'hDEADBEEF; dbyteenable = 4'hF;
        cyc();
        dwrite = 0;
        do_read(32'h1000, lat);
        chk("raw_latency", 32'(lat), 32'd4);
        chk("raw_write_first", 32'(mw_first >= 0 && mw_first < mr_first), 32'h1);
        chk("raw_data", s_rdata, 32'hDEADBEEF);

        // Timer-window vector table
        for (int i = 0; i < 6; i++) begin
            dwrite = 1; daddress = tv[i].addr; dwritedata = tv[i].data; dbyteenable = 4'hF;
            cyc();
            dwrite = 0;
            cyc();
            chk($sformatf("tv%0d_mtime", i), 32'(s_mt), 32'(tv[i].mt));
            chk($sformatf("tv%0d_mtimecmp", i), 32'(s_cmp), 32'(tv[i].cmp));
            chk($sformatf("tv%0d_upper", i), 32'(s_up), 32'(tv[i].up));
            if (tv[i].mt | tv[i].cmp) chk($sformatf("tv%0d_val", i), s_val, tv[i].data);
            chk($sformatf("tv%0d_m_write", i), 32'(s_mwrite), 32'(tv[i].avw));
            cyc();
            chk($sformatf("tv%0d_strobe_len", i), 32'(s_mt | s_cmp), 32'h0);
        end

        // Timer read completes locally with zero data
        mr_cycles = 0;
        do_read(TBASE + 32'h8, lat);
        chk("tmr_rd_latency", 32'(lat), 32'd1);
        chk("tmr_rd_no_m_read", 32'(mr_cycles), 32'd0);

        // Read with 3 wait states and readdatavalid two cycles after acceptance
        mr_cycles = 0; wait_left = 3; rdv_delay = 2;
        do_read(32'h1004, lat);
        chk("ws_latency", 32'(lat), 32'd7);
        chk("ws_m_read_cycles", 32'(mr_cycles), 32'd4);
        rdv_delay = 1;

        // Five back-to-back writes against a stalled bus: fifth is dropped
        do_reset(1);
        m_waitrequest = 1; wait_left = 21; n_avw = 0;
        for (int i = 0; i < 5; i++) begin
            dwrite = 1; daddress = 32'h1000 + 32'(4 * i); dwritedata = 32'h30000000 + 32'(i); dbyteenable = 4'hF;
            cyc();
        end
        dwrite = 0;
        cyc();
        chk("ovf_set", 32'(s_ovf), 32'h1);
        chk("ovf_no_write_yet", 32'(n_avw), 32'd0);
        for (int t = 0; t < 40 && (exp_q.size() > 0 || wait_left > 0); t++) cyc();
        chk("ovf_avalon_writes", 32'(n_avw), 32'd4);
        do_read(32'h1010, lat);
        chk("ovf_dropped_word", s_rdata, 32'hA5A50004);
        chk("ovf_sticky", 32'(s_ovf), 32'h1);

        // Reset while waiting for read data; a stale readdatavalid must be ignored
        do_reset(1);
        auto_rdv = 0;
        dread = 1; daddress = 32'h1008;
        for (int t = 0; t < 20; t++) begin
            cyc();
            if (s_acc) break;
        end
        chk("rst_rd_accepted", 32'(s_acc), 32'h1);
        do_reset(1);
        m_readdatavalid = 1; m_readdata = 32'hBAD0BAD0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("stale_m_read", 32'(s_mread), 32'h0);
            chk("stale_dwaitrequest", 32'(s_dwait), 32'h0);
            chk("stale_dreaddata", s_rdata, 32'h0);
        end
        auto_rdv = 1;
        do_read(32'h1008, lat);
        chk("post_rst_latency", 32'(lat), 32'd3);

        // Random traffic against the reference model
        do_reset(1);
        wait_rand = 1; rd_wait = 0;
        for (int it = 0; it < 600; it++) begin
            int r;
            r = $urandom_range(0, 9);
            dwrite = 0;
            if (dread) begin
                rd_wait++;
                if (rd_wait > 150) begin
                    fail_now("rand_rd_timeout", daddress);
                    dread = 0;
                end
            end else if (r < 4 || r == 5) begin
                dwrite = 1; daddress = rand_addr(); dwritedata = $urandom;
                dbyteenable = 4'($urandom_range(1, 15));
                if (r == 5) begin dread = 1; rd_wait = 0; rdv_delay = $urandom_range(1, 3); end
            end else if (r == 4) begin
                dread = 1; daddress = rand_addr(); rd_wait = 0; rdv_delay = $urandom_range(1, 3);
            end
            cyc();
            if (rd_complete) dread = 0;
        end
        dwrite = 0; wait_rand = 0;
        for (int t = 0; t < 300 && (dread || exp_q.size() > 0); t++) begin
            cyc();
            if (rd_complete) dread = 0;
        end
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        cyc();
        chk("rand_idle_m_write", 32'(s_mwrite), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
